// File: rtl/argmax_readout_sched.sv
// Readout sequencer: scans each row of the FM*WM*ADJ result memory and records
// the argmax column per node, one column compare per cycle.
module argmax_readout_sched #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int ROW_ADDR_WIDTH    = 5,
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int RD_LATENCY        = 1,
    parameter int SIGNED_CMP        = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    output logic [ROW_ADDR_WIDTH-1:0]                   read_row,
    output logic                                        rd_en,
    input  logic [DOT_PROD_WIDTH*WEIGHT_COLS-1:0]       row_in,
    output logic                                        result_we,
    output logic [ROW_ADDR_WIDTH-1:0]                   result_row,
    output logic [MAX_ADDRESS_WIDTH-1:0]                result_idx,
    output logic [MAX_ADDRESS_WIDTH*FEATURE_ROWS-1:0]   max_addi_ans,
    output logic                                        busy,
    output logic                                        done
);
    // state   | meaning
    // IDLE    | waiting for start
    // ISSUE   | read_row driven, rd_en high
    // WAIT    | absorbing remaining read latency
    // CAPTURE | latch row, seed best with column 0
    // CMP     | compare one column per cycle
    // WRITE   | store best index for this row
    // DONE    | one-cycle done pulse
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] CMP     = 3'd4;
    localparam logic [2:0] WRITE   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam int COL_W = $clog2(WEIGHT_COLS + 1);
    localparam logic [COL_W-1:0]          LAST_COL = COL_W'(WEIGHT_COLS - 1);
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);

    logic [2:0]                              state;
    logic [ROW_ADDR_WIDTH-1:0]               row_cnt;
    logic [COL_W-1:0]                        col;
    logic [1:0]                              wait_cnt;
    logic [DOT_PROD_WIDTH*WEIGHT_COLS-1:0]   row_reg;
    logic [DOT_PROD_WIDTH-1:0]               best_val;
    logic [MAX_ADDRESS_WIDTH-1:0]            best_idx;
    logic [DOT_PROD_WIDTH-1:0]               cur_val;
    logic                                    gt;

    assign cur_val = DOT_PROD_WIDTH'(row_reg >> (DOT_PROD_WIDTH * int'(col)));

    // strict greater-than so ties keep the lowest column index
    generate
        if (SIGNED_CMP != 0) begin : g_signed
            assign gt = $signed(cur_val) > $signed(best_val);
        end else begin : g_unsigned
            assign gt = cur_val > best_val;
        end
    endgenerate

    assign rd_en      = (state == ISSUE);
    assign result_we  = (state == WRITE);
    assign result_row = (state == WRITE) ? row_cnt : '0;
    assign result_idx = (state == WRITE) ? best_idx : '0;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            row_cnt      <= '0;
            col          <= '0;
            wait_cnt     <= '0;
            read_row     <= '0;
            row_reg      <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            max_addi_ans <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt  <= '0;
                        read_row <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (RD_LATENCY == 1) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= 2'(RD_LATENCY - 2);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) state <= CAPTURE;
                    else                  wait_cnt <= wait_cnt - 2'd1;
                end
                CAPTURE: begin
                    row_reg  <= row_in;
                    best_val <= row_in[DOT_PROD_WIDTH-1:0];
                    best_idx <= '0;
                    col      <= COL_W'(1);
                    state    <= (WEIGHT_COLS == 1) ? WRITE : CMP;
                end
                CMP: begin
                    if (gt) begin
                        best_val <= cur_val;
                        best_idx <= MAX_ADDRESS_WIDTH'(col);
                    end
                    if (col == LAST_COL) state <= WRITE;
                    else                 col   <= col + 1'b1;
                end
                WRITE: begin
                    max_addi_ans[int'(row_cnt)*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] <= best_idx;
                    if (row_cnt == LAST_ROW) begin
                        state <= DONE;
                    end else begin
                        row_cnt  <= row_cnt + 1'b1;
                        read_row <= row_cnt + 1'b1;
                        state    <= ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_readout_sched.sv
// Bench for argmax_readout_sched: three instances (unsigned, signed, 3-cycle
// latency single column) fed by latency-accurate memory models, checked against an argmax model.
module tb_argmax_readout_sched;
    localparam int FR = 6;
    localparam int WC = 3;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [AW-1:0]    read_row0, read_row1, read_row2;
    logic             rd_en0, rd_en1, rd_en2;
    logic [DW*WC-1:0] row_in01;
    logic [DW-1:0]    row_in2;
    logic             result_we0, result_we1, result_we2;
    logic [AW-1:0]    result_row0, result_row1, result_row2;
    logic [MW-1:0]    result_idx0, result_idx1, result_idx2;
    logic [MW*FR-1:0] max0, max1, max2;
    logic             busy0, busy1, busy2;
    logic             done0, done1, done2;

    argmax_readout_sched #(.SIGNED_CMP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .read_row(read_row0), .rd_en(rd_en0),
        .row_in(row_in01), .result_we(result_we0), .result_row(result_row0),
        .result_idx(result_idx0), .max_addi_ans(max0), .busy(busy0), .done(done0));

    argmax_readout_sched #(.SIGNED_CMP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .read_row(read_row1), .rd_en(rd_en1),
        .row_in(row_in01), .result_we(result_we1), .result_row(result_row1),
        .result_idx(result_idx1), .max_addi_ans(max1), .busy(busy1), .done(done1));

    argmax_readout_sched #(.WEIGHT_COLS(1), .RD_LATENCY(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .read_row(read_row2), .rd_en(rd_en2),
        .row_in(row_in2), .result_we(result_we2), .result_row(result_row2),
        .result_idx(result_idx2), .max_addi_ans(max2), .busy(busy2), .done(done2));

    // memory models: data valid only in the cycle RD_LATENCY after rd_en, junk otherwise
    logic [DW*WC-1:0] mem [FR];
    logic [DW-1:0]    mem2 [FR];
    logic             pv = 1'b0;
    logic [AW-1:0]    pa = '0;
    logic [DW*WC-1:0] junk = '0;
    logic [2:0]       pv2 = '0;
    logic [AW-1:0]    pa2 [3];
    logic [DW-1:0]    junk2 = '0;

    always @(posedge clk) begin
        pv     <= rd_en0;
        pa     <= read_row0;
        junk   <= (DW*WC)'({$urandom(), $urandom()});
        pv2    <= {pv2[1:0], rd_en2};
        pa2[0] <= read_row2;
        pa2[1] <= pa2[0];
        pa2[2] <= pa2[1];
        junk2  <= DW'($urandom());
    end

    assign row_in01 = (pv && pa < AW'(FR)) ? mem[pa] : junk;
    assign row_in2  = (pv2[2] && pa2[2] < AW'(FR)) ? mem2[pa2[2]] : junk2;

    function automatic logic [DW*WC-1:0] mk(input int c0, input int c1, input int c2);
        return {DW'(c2), DW'(c1), DW'(c0)};
    endfunction

    function automatic int argmax_ref(input logic [DW*WC-1:0] row, input bit sgn);
        int best_c = 0;
        int best_v = 0;
        for (int c = 0; c < WC; c++) begin
            logic [DW-1:0] x;
            int v;
            x = row[c*DW +: DW];
            v = sgn ? int'($signed(x)) : int'(x);
            if (c == 0 || v > best_v) begin
                best_v = v;
                best_c = c;
            end
        end
        return best_c;
    endfunction

    function automatic logic [DW-1:0] rand_elem();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 2));
        return DW'($urandom());
    endfunction

    task automatic fill_random();
        for (int r = 0; r < FR; r++) begin
            mem[r]  = {rand_elem(), rand_elem(), rand_elem()};
            mem2[r] = rand_elem();
        end
    endtask

    // one full scan on all instances; repulse_cyc>0 re-asserts start during that cycle
    task automatic scan_and_check(input string tag, input int repulse_cyc);
        int exp0 [FR];
        int exp1 [FR];
        for (int r = 0; r < FR; r++) begin
            exp0[r] = argmax_ref(mem[r], 1'b0);
            exp1[r] = argmax_ref(mem[r], 1'b1);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            logic [3:0] exp_ctl;
            bit         exp_we;
            int         r;
            start   = (cyc == repulse_cyc);
            exp_we  = (cyc % 5 == 0) && (cyc <= 30);
            r       = cyc / 5 - 1;
            exp_ctl = {(cyc % 5 == 1) && (cyc <= 26), exp_we, (cyc <= 30), (cyc == 31)};
            total += 3;
            if ({rd_en0, result_we0, busy0, done0} !== exp_ctl) begin
                bad++;
                $display("FAIL %s ctl0 cyc=%0d got=%b exp=%b", tag, cyc,
                         {rd_en0, result_we0, busy0, done0}, exp_ctl);
            end
            if ({rd_en1, result_we1, busy1, done1} !== exp_ctl) begin
                bad++;
                $display("FAIL %s ctl1 cyc=%0d got=%b exp=%b", tag, cyc,
                         {rd_en1, result_we1, busy1, done1}, exp_ctl);
            end
            if ({rd_en2, result_we2, busy2, done2} !== exp_ctl) begin
                bad++;
                $display("FAIL %s ctl2 cyc=%0d got=%b exp=%b", tag, cyc,
                         {rd_en2, result_we2, busy2, done2}, exp_ctl);
            end
            if (exp_ctl[3]) begin
                total++;
                if (read_row0 !== AW'((cyc - 1) / 5)) begin
                    bad++;
                    $display("FAIL %s read_row0 cyc=%0d got=%0d exp=%0d", tag, cyc, read_row0, (cyc - 1) / 5);
                end
            end
            if ((cyc % 5 >= 1) && (cyc % 5 <= 3) && cyc <= 28) begin
                total++;
                if (read_row2 !== AW'(cyc / 5)) begin
                    bad++;
                    $display("FAIL %s read_row2_hold cyc=%0d got=%0d exp=%0d", tag, cyc, read_row2, cyc / 5);
                end
            end
            if (exp_we) begin
                total += 4;
                if (result_row0 !== AW'(r) || result_row2 !== AW'(r)) begin
                    bad++;
                    $display("FAIL %s result_row cyc=%0d got=%0d/%0d exp=%0d", tag, cyc, result_row0, result_row2, r);
                end
                if (result_idx0 !== MW'(exp0[r])) begin
                    bad++;
                    $display("FAIL %s idx_unsigned row=%0d got=%0d exp=%0d", tag, r, result_idx0, exp0[r]);
                end
                if (result_idx1 !== MW'(exp1[r])) begin
                    bad++;
                    $display("FAIL %s idx_signed row=%0d got=%0d exp=%0d", tag, r, result_idx1, exp1[r]);
                end
                if (result_idx2 !== '0) begin
                    bad++;
                    $display("FAIL %s idx_single_col row=%0d got=%0d exp=0", tag, r, result_idx2);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int r = 0; r < FR; r++) begin
            total += 3;
            if (max0[r*MW +: MW] !== MW'(exp0[r])) begin
                bad++;
                $display("FAIL %s max0[%0d] got=%0d exp=%0d", tag, r, max0[r*MW +: MW], exp0[r]);
            end
            if (max1[r*MW +: MW] !== MW'(exp1[r])) begin
                bad++;
                $display("FAIL %s max1[%0d] got=%0d exp=%0d", tag, r, max1[r*MW +: MW], exp1[r]);
            end
            if (max2[r*MW +: MW] !== '0) begin
                bad++;
                $display("FAIL %s max2[%0d] got=%0d exp=0", tag, r, max2[r*MW +: MW]);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        total++;
        if ({rd_en0, result_we0, busy0, done0, read_row0, max0, result_row0, result_idx0} !== '0) begin
            bad++;
            $display("FAIL reset_state got rd=%b we=%b busy=%b done=%b max=%h exp=0",
                     rd_en0, result_we0, busy0, done0, max0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy0, busy1, busy2, rd_en0, rd_en2} !== '0) begin
            bad++;
            $display("FAIL idle_without_start got=%b exp=0", {busy0, busy1, busy2, rd_en0, rd_en2});
        end
    endtask

    task automatic test_const_rows();
        for (int r = 0; r < FR; r++) begin
            mem[r]  = mk(0, 2, 1);
            mem2[r] = DW'(r);
        end
        scan_and_check("const_rows", 0);
        total++;
        if (max0 !== {FR{2'b01}}) begin
            bad++;
            $display("FAIL const_rows_all_one got=%h exp=%h", max0, {FR{2'b01}});
        end
    endtask

    task automatic test_distinct_winners();
        mem[0] = mk(9, 3, 3);
        mem[1] = mk(1, 7, 2);
        mem[2] = mk(0, 0, 4);
        mem[3] = mk(5, 5, 5);
        mem[4] = mk(2, 8, 8);
        mem[5] = mk(3, 1, 9);
        for (int r = 0; r < FR; r++) mem2[r] = DW'($urandom());
        scan_and_check("winners", 0);
        total++;
        if (max0 !== {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}) begin
            bad++;
            $display("FAIL winners_table got=%h exp=%h", max0, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
        end
    endtask

    task automatic test_signed_cmp();
        for (int r = 0; r < FR; r++) mem[r] = {16'hFFFF, 16'h0001, 16'h8000};
        scan_and_check("signed", 0);
        total += 2;
        if (max1 !== {FR{2'd1}}) begin
            bad++;
            $display("FAIL signed_cmp got=%h exp=%h", max1, {FR{2'd1}});
        end
        if (max0 !== {FR{2'd2}}) begin
            bad++;
            $display("FAIL unsigned_cmp got=%h exp=%h", max0, {FR{2'd2}});
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        scan_and_check("start_ignored", 10);
    endtask

    task automatic test_reset_mid_scan();
        for (int r = 0; r < FR; r++) mem[r] = mk(0, 7, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total += 2;
        if ({rd_en0, result_we0, busy0, done0, read_row0, result_row0, result_idx0} !== '0) begin
            bad++;
            $display("FAIL midscan_reset_outputs got rd=%b we=%b busy=%b row=%0d exp=0",
                     rd_en0, result_we0, busy0, read_row0);
        end
        if ({max0, max1, max2} !== '0) begin
            bad++;
            $display("FAIL midscan_reset_array got=%h/%h exp=0", max0, max1);
        end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        fill_random();
        @(posedge clk);
        #1;
        scan_and_check("after_reset", 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            fill_random();
            scan_and_check("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_const_rows();
        test_distinct_winners();
        test_signed_cmp();
        test_start_ignored();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
